mux_rr_nx1: RTL and testbench
=============================

// Module: mux_rr_nx1
// PURPOSE
//  - Registered N:1 stream multiplexer. Selection comes from an internal round-robin
//    arbiter, not from an external control input.
//  - Each input channel has a valid/ready handshake. The output is one registered
//    pipeline stage.
//  - Merges several requesters into one consumer, e.g. fetch/load/store onto one
//    memory port. Next generation of the fixed 4:1 combinational selector.
// PARAMETERS
//  WIDTH     32  payload width per channel (`INSTRUCTION_WIDTH)
//  CHANNELS  4   number of input channels, >=2; need not be a power of two
//  SEL_W     localparam = max(1,$clog2(CHANNELS)); width of channel index
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   CHANNELS        per-channel request; bit i = channel i
//  in_data    in   CHANNELS*WIDTH  channel i payload at [i*WIDTH +: WIDTH]
//  in_ready   out  CHANNELS        per-channel accept; one-hot or all-zero
//  out_valid  out  1               output register holds a beat
//  out_data   out  WIDTH           registered payload
//  out_sel    out  SEL_W           index of the channel that sourced out_data
//  out_ready  in   1               consumer accepts beat when out_valid&out_ready
// BEHAVIOUR
//  - Reset: async assert. out_valid=0, out_data=0, out_sel=0, ptr=0, lock=0.
//    in_ready=0 while rst_n=0. Any beat in flight is discarded.
//  - load = !out_valid | out_ready. This gives full throughput: one beat per cycle.
//  - Arbitration (comb): when load is high and in_valid!=0, grant g is the first
//    channel with in_valid set, searching from ptr upward modulo CHANNELS.
//    in_ready[g]=1; all other bits 0. When load=0 or no request, in_ready=0.
//  - in_ready may depend combinationally on in_valid and out_ready. in_valid must not
//    depend on in_ready.
//  - Clock edge with a grant: out_data<=in_data[g], out_sel<=g, out_valid<=1.
//    ptr<=(g==CHANNELS-1)?0:g+1. The wrap is explicit for non-power-of-two CHANNELS.
//  - Clock edge with load=1 and no request: out_valid<=0. out_data and out_sel keep
//    their values.
//  - Clock edge with load=0 (stall): out_valid, out_data, out_sel and ptr all hold.
//  - Latency: input accept to out_valid is 1 cycle. Simultaneous out_ready pop and
//    new grant in the same cycle is legal and gives a back-to-back beat.
//  - Fairness: a continuously-valid channel waits at most CHANNELS-1 grants.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Adds ports in_last (in, CHANNELS) and out_last (out, 1). out_last is registered
//    with out_data and resets to 0.
//  - A granted beat with in_last[g]=0 sets lock=1, lock_ch=g.
//  - While locked, only lock_ch may be granted. Other channels see in_ready=0 even if
//    lock_ch is idle.
//  - The granted beat with in_last=1 clears lock. ptr advances only on that beat.
//  - Reset clears lock.
//  ARB_LOCK_EN undefined:
//  - No in_last/out_last ports. Every beat is arbitrated independently and ptr
//    advances on every grant.
// TESTING
//  1. rst_n=0, all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
//     Release reset -> first grant is ch0.
//  2. CHANNELS=4, all valid, out_ready=1, data_i=32'hA0+i -> out_sel 0,1,2,3,0,...
//     one per cycle, with out_data matching.
//  3. Only ch2 valid for 4 cycles -> in_ready=4'b0100 each cycle; out_sel=2 and
//     out_valid=1 continuously.
//  4. out_valid=1, out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0.
//     out_ready=1 -> pop and next grant in the same cycle.
//  5. CHANNELS=3, all valid -> out_sel 0,1,2,0,1 (wrap at 2). Assert rst_n=0 mid-run
//     -> out_valid=0 immediately; ptr restarts at 0.
//  6. ARB_LOCK_EN: ch1 sends 3 beats (last on beat 3) while ch0 valid -> out_sel 1,1,1,0.
//     Without the macro -> out_sel 0,1,0,1...

Source files
------------

// File: rtl/mux_rr_nx1.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_nx1
// Description : Registered N:1 valid/ready stream mux with an internal
//               round-robin arbiter. Define ARB_LOCK_EN to add packet
//               locking (in_last/out_last) so multi-beat bursts stay atomic.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_nx1 #(
    parameter int   WIDTH    = 32,
    parameter int   CHANNELS = 4,
    localparam int  SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef ARB_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
`ifdef ARB_LOCK_EN
    output logic                      out_last,
`endif
    input  logic                      out_ready
);

    localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(CHANNELS - 1);

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [SEL_W-1:0]     r_out_sel;
    logic [SEL_W-1:0]     r_ptr;

    logic                 w_load;
    logic [CHANNELS-1:0]  w_req;
    logic                 w_found;
    logic [SEL_W-1:0]     w_gnt;
    logic                 w_fire;
    logic                 w_adv;
    logic [SEL_W-1:0]     w_ptr_nxt;
    int                   w_idx;

    assign w_load = ~r_out_valid | out_ready;

`ifdef ARB_LOCK_EN
    logic                 r_lock;
    logic [SEL_W-1:0]     r_lock_ch;
    logic                 r_out_last;

    // A locked channel owns the output even while it is idle.
    assign w_req = r_lock ? (in_valid & (CHANNELS'(1) << r_lock_ch)) : in_valid;
    assign w_adv = w_fire & in_last[w_gnt];
`else
    assign w_req = in_valid;
    assign w_adv = w_fire;
`endif

    // First requester at or above ptr, wrapping modulo CHANNELS.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = SEL_W'(w_idx);
            end
        end
    end

    assign w_fire    = rst_n & w_load & w_found;
    assign in_ready  = w_fire ? (CHANNELS'(1) << w_gnt) : '0;
    assign w_ptr_nxt = (w_gnt == c_LAST_CH) ? '0 : w_gnt + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= in_data[w_gnt*WIDTH +: WIDTH];
                r_out_sel  <= w_gnt;
            end
            if (w_adv) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_ch  <= '0;
            r_out_last <= 1'b0;
        end else if (w_fire) begin
            r_lock     <= ~in_last[w_gnt];
            r_lock_ch  <= w_gnt;
            r_out_last <= in_last[w_gnt];
        end
    end

    assign out_last = r_out_last;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_nx1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_nx1
// Description : Directed self-checking bench; 4-channel and 3-channel DUTs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_nx1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 4-channel instance
    logic          a_rst_n;
    logic [3:0]    a_in_valid;
    logic [127:0]  a_in_data;
    logic [3:0]    a_in_ready;
    logic          a_out_valid;
    logic [31:0]   a_out_data;
    logic [1:0]    a_out_sel;
    logic          a_out_ready;

    // 3-channel instance
    logic          b_rst_n;
    logic [2:0]    b_in_valid;
    logic [95:0]   b_in_data;
    logic [2:0]    b_in_ready;
    logic          b_out_valid;
    logic [31:0]   b_out_data;
    logic [1:0]    b_out_sel;
    logic          b_out_ready;

`ifdef ARB_LOCK_EN
    logic [3:0]    a_in_last;
    logic          a_out_last;
    logic [2:0]    b_in_last;
    logic          b_out_last;
`endif

    assign a_in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    assign b_in_data = {32'hA2, 32'hA1, 32'hA0};

    mux_rr_nx1 #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
`ifdef ARB_LOCK_EN
        .in_last   (a_in_last),
`endif
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
`ifdef ARB_LOCK_EN
        .out_last  (a_out_last),
`endif
        .out_ready (a_out_ready)
    );

    mux_rr_nx1 #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
`ifdef ARB_LOCK_EN
        .in_last   (b_in_last),
`endif
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
`ifdef ARB_LOCK_EN
        .out_last  (b_out_last),
`endif
        .out_ready (b_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n     = 1'b0;
        b_rst_n     = 1'b0;
        a_in_valid  = 4'hF;
        b_in_valid  = 3'h7;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
`ifdef ARB_LOCK_EN
        a_in_last   = 4'hF;
        b_in_last   = 3'h7;
`endif
        repeat (3) tick;

        // Reset state with every channel requesting
        check("rst_in_ready",  32'(a_in_ready),  32'h0);
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_out_data",  a_out_data,       32'h0);
        check("rst_out_sel",   32'(a_out_sel),   32'h0);

        a_rst_n = 1'b1;
        #1;
        check("first_grant", 32'(a_in_ready), 32'h1);

        // Full rotation, one beat per cycle
        for (int k = 0; k < 6; k++) begin
            tick;
            check("rr_sel",   32'(a_out_sel),   32'(k % 4));
            check("rr_data",  a_out_data,       32'hA0 + 32'(k % 4));
            check("rr_valid", 32'(a_out_valid), 32'h1);
            check("rr_ready", 32'(a_in_ready),  32'h1 << ((k + 1) % 4));
        end

        // Single requester streams continuously
        a_in_valid = 4'b0100;
        #1;
        check("solo_ready0", 32'(a_in_ready), 32'h4);
        for (int k = 0; k < 4; k++) begin
            tick;
            check("solo_sel",   32'(a_out_sel),   32'h2);
            check("solo_data",  a_out_data,       32'hA2);
            check("solo_valid", 32'(a_out_valid), 32'h1);
            check("solo_ready", 32'(a_in_ready),  32'h4);
        end

        // Back-pressure stall
        a_in_valid  = 4'hF;
        a_out_ready = 1'b0;
        #1;
        check("stall_ready0", 32'(a_in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("stall_sel",   32'(a_out_sel),   32'h2);
            check("stall_data",  a_out_data,       32'hA2);
            check("stall_valid", 32'(a_out_valid), 32'h1);
            check("stall_ready", 32'(a_in_ready),  32'h0);
        end
        a_out_ready = 1'b1;
        #1;
        check("pop_ready", 32'(a_in_ready), 32'h8);
        tick;
        check("pop_sel",  32'(a_out_sel), 32'h3);
        check("pop_data", a_out_data,     32'hA3);

        // No request: valid drops, payload holds
        a_in_valid = 4'h0;
        tick;
        check("idle_valid", 32'(a_out_valid), 32'h0);
        check("idle_sel",   32'(a_out_sel),   32'h3);
        check("idle_data",  a_out_data,       32'hA3);

`ifdef ARB_LOCK_EN
        // ch0 single beat moves ptr to 1, then ch1 sends a 3-beat burst
        a_in_valid = 4'b0001;
        tick;
        check("lk_pre_sel", 32'(a_out_sel), 32'h0);
        a_in_valid = 4'b0011;
        a_in_last  = 4'b1101;
        #1;
        check("lk_ready1", 32'(a_in_ready), 32'h2);
        tick;
        check("lk_sel1",  32'(a_out_sel),  32'h1);
        check("lk_last1", 32'(a_out_last), 32'h0);
        a_in_valid = 4'b0001;
        #1;
        check("lk_block", 32'(a_in_ready), 32'h0);
        tick;
        check("lk_gap_valid", 32'(a_out_valid), 32'h0);
        a_in_valid = 4'b0011;
        #1;
        check("lk_ready2", 32'(a_in_ready), 32'h2);
        tick;
        check("lk_sel2", 32'(a_out_sel), 32'h1);
        a_in_last = 4'hF;
        tick;
        check("lk_sel3",  32'(a_out_sel),  32'h1);
        check("lk_last3", 32'(a_out_last), 32'h1);
        check("lk_release_ready", 32'(a_in_ready), 32'h1);
        tick;
        check("lk_sel4", 32'(a_out_sel), 32'h0);
        a_in_valid = 4'h0;
`else
        // Two contenders alternate beat by beat
        a_in_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("alt_sel", 32'(a_out_sel), 32'(k % 2));
        end
        a_in_valid = 4'h0;
`endif

        // Non-power-of-two channel count wraps at 2
        b_rst_n = 1'b1;
        #1;
        check("c3_first", 32'(b_in_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick;
            check("c3_sel",  32'(b_out_sel), 32'(k % 3));
            check("c3_data", b_out_data,     32'hA0 + 32'(k % 3));
        end

        // Asynchronous reset mid-cycle
        #2;
        b_rst_n = 1'b0;
        #1;
        check("c3_arst_valid", 32'(b_out_valid), 32'h0);
        check("c3_arst_ready", 32'(b_in_ready),  32'h0);
        check("c3_arst_sel",   32'(b_out_sel),   32'h0);
        tick;
        b_rst_n = 1'b1;
        #1;
        check("c3_ptr_restart", 32'(b_in_ready), 32'h1);
        tick;
        check("c3_after_sel",   32'(b_out_sel),   32'h0);
        check("c3_after_valid", 32'(b_out_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
